// File: rtl/alu_issue_queue_if.sv
// alu_issue_queue_if: dispatch, CDB, ALU-busy and issue bundle for alu_issue_queue.
//   master : dispatch stage / CDB / ALU side (drives disp_*, cdb_*, alu_busy)
//   slave  : the issue queue (drives disp_ready, issue_*, count)
// Signals:
//   disp_valid/disp_ready          dispatch handshake
//   disp_optype/dr/src*/imm        micro-op being dispatched
//   cdb_valid/cdb_tag/cdb_data     result broadcast
//   alu_busy[NUM_ALU]              per-ALU busy, bit i = ALU i cannot accept
//   issue_alu_number (one-hot)     target ALU of the issued op, 0 = no issue
//   issue_optype/sr1/sr2/imm/dr    issued op payload (registered)
//   count                          occupied entries
interface alu_issue_queue_if #(
  parameter int DEPTH   = 8,
  parameter int NUM_ALU = 3,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                disp_valid;
  logic                disp_ready;
  logic [3:0]          disp_optype;
  logic [TAG_W-1:0]    disp_dr;
  logic [TAG_W-1:0]    disp_src1_tag;
  logic [TAG_W-1:0]    disp_src2_tag;
  logic                disp_src1_rdy;
  logic                disp_src2_rdy;
  logic [DATA_W-1:0]   disp_src1_data;
  logic [DATA_W-1:0]   disp_src2_data;
  logic [DATA_W-1:0]   disp_imm;

  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [DATA_W-1:0]   cdb_data;

  logic [NUM_ALU-1:0]  alu_busy;

  logic [NUM_ALU-1:0]  issue_alu_number;
  logic [3:0]          issue_optype;
  logic [DATA_W-1:0]   issue_sr1;
  logic [DATA_W-1:0]   issue_sr2;
  logic [DATA_W-1:0]   issue_imm;
  logic [TAG_W-1:0]    issue_dr;
  logic [CNT_W-1:0]    count;

  modport master (
    output disp_valid, disp_optype, disp_dr, disp_src1_tag, disp_src2_tag,
           disp_src1_rdy, disp_src2_rdy, disp_src1_data, disp_src2_data, disp_imm,
           cdb_valid, cdb_tag, cdb_data, alu_busy,
    input  disp_ready, issue_alu_number, issue_optype, issue_sr1, issue_sr2,
           issue_imm, issue_dr, count
  );

  modport slave (
    input  disp_valid, disp_optype, disp_dr, disp_src1_tag, disp_src2_tag,
           disp_src1_rdy, disp_src2_rdy, disp_src1_data, disp_src2_data, disp_imm,
           cdb_valid, cdb_tag, cdb_data, alu_busy,
    output disp_ready, issue_alu_number, issue_optype, issue_sr1, issue_sr2,
           issue_imm, issue_dr, count
  );
endinterface

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: compacted, oldest-first issue queue in front of the ALU bank.
// Holds dispatched micro-ops until their needed sources are ready, captures
// operands from the CDB (including same-cycle dispatch bypass) and issues at
// most one op per cycle to the lowest-numbered free ALU.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_issue_queue_if.slave (dispatch, CDB, alu_busy, issue outputs, count)
module alu_issue_queue #(
  parameter int DEPTH   = 8,
  parameter int NUM_ALU = 3,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_queue_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [3:0]        optype;
    logic [TAG_W-1:0]  dr;
    logic              s1_rdy;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_data;
    logic              s2_rdy;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_data;
    logic [DATA_W-1:0] imm;
  } entry_t;

  entry_t             r_q    [DEPTH];
  entry_t             w_wake [DEPTH];
  entry_t             w_nxt  [DEPTH];
  entry_t             w_new;
  logic [CNT_W-1:0]   r_count;

  logic [NUM_ALU-1:0] r_issue_alu;
  logic [3:0]         r_issue_optype;
  logic [DATA_W-1:0]  r_issue_sr1;
  logic [DATA_W-1:0]  r_issue_sr2;
  logic [DATA_W-1:0]  r_issue_imm;
  logic [TAG_W-1:0]   r_issue_dr;

  logic               w_sel_found;
  logic [CNT_W-1:0]   w_sel_idx;
  logic [3:0]         w_sel_optype;
  logic [TAG_W-1:0]   w_sel_dr;
  logic [DATA_W-1:0]  w_sel_sr1;
  logic [DATA_W-1:0]  w_sel_sr2;
  logic [DATA_W-1:0]  w_sel_imm;
  logic               w_alu_found;
  logic [NUM_ALU-1:0] w_alu_oh;
  logic               w_issue;
  logic               w_disp_ready;
  logic               w_disp_legal;
  logic               w_accept;
  logic [CNT_W-1:0]   w_wr_idx;

  // LUI ignores src1; only ADD, XOR, SB, SW read src2. Unneeded sources count as ready.
  function automatic logic f_elig(input logic valid, input logic [3:0] op,
                                  input logic rdy1, input logic rdy2);
    logic need1;
    logic need2;
    need1 = (op != 4'd3);
    need2 = (op == 4'd1) || (op == 4'd5) || (op == 4'd9) || (op == 4'd10);
    return valid && (!need1 || rdy1) && (!need2 || rdy2);
  endfunction

  // Select on start-of-cycle ready bits only, so a CDB wakeup never issues in the same cycle.
  always_comb begin
    w_sel_found  = 1'b0;
    w_sel_idx    = '0;
    w_sel_optype = '0;
    w_sel_dr     = '0;
    w_sel_sr1    = '0;
    w_sel_sr2    = '0;
    w_sel_imm    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!w_sel_found && f_elig(r_q[i].valid, r_q[i].optype, r_q[i].s1_rdy, r_q[i].s2_rdy)) begin
        w_sel_found  = 1'b1;
        w_sel_idx    = CNT_W'(i);
        w_sel_optype = r_q[i].optype;
        w_sel_dr     = r_q[i].dr;
        w_sel_sr1    = r_q[i].s1_data;
        w_sel_sr2    = r_q[i].s2_data;
        w_sel_imm    = r_q[i].imm;
      end
    end
  end

  always_comb begin
    w_alu_oh    = '0;
    w_alu_found = 1'b0;
    for (int unsigned i = 0; i < NUM_ALU; i++) begin
      if (!w_alu_found && !bus.alu_busy[i]) begin
        w_alu_oh[i] = 1'b1;
        w_alu_found = 1'b1;
      end
    end
  end

  assign w_issue      = w_sel_found && w_alu_found;
  assign w_disp_ready = (r_count < CNT_W'(DEPTH)) && !rst;
  assign w_disp_legal = (bus.disp_optype != 4'd0) && (bus.disp_optype <= 4'd10);
  assign w_accept     = bus.disp_valid && w_disp_ready && w_disp_legal;
  assign w_wr_idx     = w_issue ? (r_count - CNT_W'(1)) : r_count;

  // Incoming entry, with CDB bypass for sources that are not yet ready.
  always_comb begin
    w_new         = '0;
    w_new.valid   = 1'b1;
    w_new.optype  = bus.disp_optype;
    w_new.dr      = bus.disp_dr;
    w_new.s1_rdy  = bus.disp_src1_rdy;
    w_new.s1_tag  = bus.disp_src1_tag;
    w_new.s1_data = bus.disp_src1_data;
    w_new.s2_rdy  = bus.disp_src2_rdy;
    w_new.s2_tag  = bus.disp_src2_tag;
    w_new.s2_data = bus.disp_src2_data;
    w_new.imm     = bus.disp_imm;
    if (bus.cdb_valid && !bus.disp_src1_rdy && (bus.disp_src1_tag == bus.cdb_tag)) begin
      w_new.s1_rdy  = 1'b1;
      w_new.s1_data = bus.cdb_data;
    end
    if (bus.cdb_valid && !bus.disp_src2_rdy && (bus.disp_src2_tag == bus.cdb_tag)) begin
      w_new.s2_rdy  = 1'b1;
      w_new.s2_data = bus.cdb_data;
    end
  end

  // Next queue image: wakeup, then compaction over the issued slot, then dispatch write.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_wake[i] = r_q[i];
      if (bus.cdb_valid && r_q[i].valid) begin
        if (!r_q[i].s1_rdy && (r_q[i].s1_tag == bus.cdb_tag)) begin
          w_wake[i].s1_rdy  = 1'b1;
          w_wake[i].s1_data = bus.cdb_data;
        end
        if (!r_q[i].s2_rdy && (r_q[i].s2_tag == bus.cdb_tag)) begin
          w_wake[i].s2_rdy  = 1'b1;
          w_wake[i].s2_data = bus.cdb_data;
        end
      end
    end
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      if (w_issue && (CNT_W'(i) >= w_sel_idx)) begin
        w_nxt[i] = w_wake[i + 1];
      end else begin
        w_nxt[i] = w_wake[i];
      end
    end
    if (w_issue) begin
      w_nxt[DEPTH-1] = '0;
    end else begin
      w_nxt[DEPTH-1] = w_wake[DEPTH-1];
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_accept && (CNT_W'(i) == w_wr_idx)) begin
        w_nxt[i] = w_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_count        <= '0;
      r_issue_alu    <= '0;
      r_issue_optype <= '0;
      r_issue_sr1    <= '0;
      r_issue_sr2    <= '0;
      r_issue_imm    <= '0;
      r_issue_dr     <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q[i] <= w_nxt[i];
      end
      case ({w_accept, w_issue})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_issue) begin
        r_issue_alu    <= w_alu_oh;
        r_issue_optype <= w_sel_optype;
        r_issue_sr1    <= w_sel_sr1;
        r_issue_sr2    <= w_sel_sr2;
        r_issue_imm    <= w_sel_imm;
        r_issue_dr     <= w_sel_dr;
      end else begin
        r_issue_alu    <= '0;
      end
    end
  end

  assign bus.disp_ready       = w_disp_ready;
  assign bus.issue_alu_number = r_issue_alu;
  assign bus.issue_optype     = r_issue_optype;
  assign bus.issue_sr1        = r_issue_sr1;
  assign bus.issue_sr2        = r_issue_sr2;
  assign bus.issue_imm        = r_issue_imm;
  assign bus.issue_dr         = r_issue_dr;
  assign bus.count            = r_count;
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed self-checking bench for alu_issue_queue.
module tb_alu_issue_queue;
  logic clk = 1'b0;
  logic rst;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  alu_issue_queue_if #(.DEPTH(8), .NUM_ALU(3), .TAG_W(6), .DATA_W(32)) bus ();

  alu_issue_queue #(.DEPTH(8), .NUM_ALU(3), .TAG_W(6), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [5:0] dr,
                       input logic [5:0] t1, input logic r1, input logic [31:0] d1,
                       input logic [5:0] t2, input logic r2, input logic [31:0] d2,
                       input logic [31:0] imm);
    bus.disp_valid     = 1'b1;
    bus.disp_optype    = op;
    bus.disp_dr        = dr;
    bus.disp_src1_tag  = t1;
    bus.disp_src1_rdy  = r1;
    bus.disp_src1_data = d1;
    bus.disp_src2_tag  = t2;
    bus.disp_src2_rdy  = r2;
    bus.disp_src2_data = d2;
    bus.disp_imm       = imm;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] d);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = t;
    bus.cdb_data  = d;
  endtask

  task automatic test_back_to_back();
    bus.alu_busy = 3'b000;
    drive(4'd2, 6'd12, 6'd0, 1'b1, 32'd5, 6'd63, 1'b0, 32'd0, 32'd7);  // ADDI, src2 unneeded
    step();
    n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL b2b_count0 got %0d exp 1", bus.count); end
    drive(4'd4, 6'd13, 6'd0, 1'b1, 32'd9, 6'd0, 1'b0, 32'd0, 32'd3);   // ORI
    step();
    idle();
    n_vec++; if (bus.issue_alu_number !== 3'b001) begin n_err++; $display("FAIL b2b_alu_a got %b exp 001", bus.issue_alu_number); end
    n_vec++; if (bus.issue_optype !== 4'd2) begin n_err++; $display("FAIL b2b_optype_a got %0d exp 2", bus.issue_optype); end
    n_vec++; if (bus.issue_sr1 !== 32'd5) begin n_err++; $display("FAIL b2b_sr1_a got %0d exp 5", bus.issue_sr1); end
    n_vec++; if (bus.issue_imm !== 32'd7) begin n_err++; $display("FAIL b2b_imm_a got %0d exp 7", bus.issue_imm); end
    n_vec++; if (bus.issue_dr !== 6'd12) begin n_err++; $display("FAIL b2b_dr_a got %0d exp 12", bus.issue_dr); end
    n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL b2b_count1 got %0d exp 1", bus.count); end
    step();
    n_vec++; if (bus.issue_alu_number !== 3'b001) begin n_err++; $display("FAIL b2b_alu_b got %b exp 001", bus.issue_alu_number); end
    n_vec++; if (bus.issue_optype !== 4'd4) begin n_err++; $display("FAIL b2b_optype_b got %0d exp 4", bus.issue_optype); end
    n_vec++; if (bus.issue_sr1 !== 32'd9) begin n_err++; $display("FAIL b2b_sr1_b got %0d exp 9", bus.issue_sr1); end
    n_vec++; if (bus.issue_dr !== 6'd13) begin n_err++; $display("FAIL b2b_dr_b got %0d exp 13", bus.issue_dr); end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL b2b_count2 got %0d exp 0", bus.count); end
    step();
    n_vec++; if (bus.issue_alu_number !== 3'b000) begin n_err++; $display("FAIL b2b_one_cycle got %b exp 000", bus.issue_alu_number); end
    n_vec++; if (bus.issue_dr !== 6'd13) begin n_err++; $display("FAIL b2b_hold_dr got %0d exp 13", bus.issue_dr); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'd1, 6'(20 + i), 6'd40, 1'b0, 32'd0, 6'd0, 1'b1, 32'd1, 32'd0);
      step();
    end
    idle();
    n_vec++; if (bus.count !== 4'd3) begin n_err++; $display("FAIL rst_pre_count got %0d exp 3", bus.count); end
    rst = 1'b1;
    drive(4'd2, 6'd15, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd0, 32'd1);
    #1;
    n_vec++; if (bus.disp_ready !== 1'b0) begin n_err++; $display("FAIL rst_disp_ready_hi got %b exp 0", bus.disp_ready); end
    step();
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    n_vec++; if (bus.issue_alu_number !== 3'b000) begin n_err++; $display("FAIL rst_alu got %b exp 000", bus.issue_alu_number); end
    n_vec++; if (bus.issue_optype !== 4'd0) begin n_err++; $display("FAIL rst_optype got %0d exp 0", bus.issue_optype); end
    n_vec++; if (bus.issue_dr !== 6'd0) begin n_err++; $display("FAIL rst_dr got %0d exp 0", bus.issue_dr); end
    n_vec++; if (bus.issue_sr1 !== 32'd0) begin n_err++; $display("FAIL rst_sr1 got %0d exp 0", bus.issue_sr1); end
    n_vec++; if (bus.issue_imm !== 32'd0) begin n_err++; $display("FAIL rst_imm got %0d exp 0", bus.issue_imm); end
    rst = 1'b0;
    idle();
    #1;
    n_vec++; if (bus.disp_ready !== 1'b1) begin n_err++; $display("FAIL rst_disp_ready_lo got %b exp 1", bus.disp_ready); end
    cdb(6'd40, 32'd1);
    step();
    idle();
    step();
    n_vec++; if (bus.issue_alu_number !== 3'b000) begin n_err++; $display("FAIL rst_discard_alu got %b exp 000", bus.issue_alu_number); end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rst_discard_count got %0d exp 0", bus.count); end
  endtask

  task automatic test_cdb_wakeup();
    drive(4'd1, 6'd21, 6'd20, 1'b0, 32'd0, 6'd0, 1'b1, 32'd3, 32'd0);  // ADD waits on tag 20
    step();
    drive(4'd5, 6'd22, 6'd0, 1'b1, 32'd6, 6'd0, 1'b1, 32'd1, 32'd0);   // XOR ready
    step();
    idle();
    step();
    n_vec++; if (bus.issue_alu_number !== 3'b001) begin n_err++; $display("FAIL cdb_xor_alu got %b exp 001", bus.issue_alu_number); end
    n_vec++; if (bus.issue_dr !== 6'd22) begin n_err++; $display("FAIL cdb_xor_dr got %0d exp 22", bus.issue_dr); end
    n_vec++; if (bus.issue_optype !== 4'd5) begin n_err++; $display("FAIL cdb_xor_optype got %0d exp 5", bus.issue_optype); end
    n_vec++; if (bus.issue_sr2 !== 32'd1) begin n_err++; $display("FAIL cdb_xor_sr2 got %0d exp 1", bus.issue_sr2); end
    n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL cdb_count1 got %0d exp 1", bus.count); end
    cdb(6'd20, 32'h10);
    step();
    idle();
    n_vec++; if (bus.issue_alu_number !== 3'b000) begin n_err++; $display("FAIL cdb_no_same_cycle got %b exp 000", bus.issue_alu_number); end
    step();
    n_vec++; if (bus.issue_alu_number !== 3'b001) begin n_err++; $display("FAIL cdb_add_alu got %b exp 001", bus.issue_alu_number); end
    n_vec++; if (bus.issue_dr !== 6'd21) begin n_err++; $display("FAIL cdb_add_dr got %0d exp 21", bus.issue_dr); end
    n_vec++; if (bus.issue_sr1 !== 32'h10) begin n_err++; $display("FAIL cdb_add_sr1 got %h exp 10", bus.issue_sr1); end
    n_vec++; if (bus.issue_sr2 !== 32'd3) begin n_err++; $display("FAIL cdb_add_sr2 got %0d exp 3", bus.issue_sr2); end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL cdb_count0 got %0d exp 0", bus.count); end
    drive(4'd1, 6'd23, 6'd20, 1'b0, 32'd0, 6'd0, 1'b1, 32'd3, 32'd0);
    cdb(6'd20, 32'h10);
    step();
    idle();
    n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL byp_count got %0d exp 1", bus.count); end
    step();
    n_vec++; if (bus.issue_alu_number !== 3'b001) begin n_err++; $display("FAIL byp_alu got %b exp 001", bus.issue_alu_number); end
    n_vec++; if (bus.issue_dr !== 6'd23) begin n_err++; $display("FAIL byp_dr got %0d exp 23", bus.issue_dr); end
    n_vec++; if (bus.issue_sr1 !== 32'h10) begin n_err++; $display("FAIL byp_sr1 got %h exp 10", bus.issue_sr1); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      drive(4'd2, 6'(1 + i), 6'd33, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 32'(i));
      step();
    end
    idle();
    n_vec++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL full_count got %0d exp 8", bus.count); end
    n_vec++; if (bus.disp_ready !== 1'b0) begin n_err++; $display("FAIL full_disp_ready got %b exp 0", bus.disp_ready); end
    drive(4'd5, 6'd50, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 32'd0);
    step();
    idle();
    n_vec++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL full_ignored got %0d exp 8", bus.count); end
    cdb(6'd34, 32'h99);
    step();
    idle();
    step();
    n_vec++; if (bus.issue_alu_number !== 3'b000) begin n_err++; $display("FAIL full_wrong_tag got %b exp 000", bus.issue_alu_number); end
    cdb(6'd33, 32'hAB);
    step();
    idle();
    n_vec++; if (bus.issue_alu_number !== 3'b000) begin n_err++; $display("FAIL full_wake_cycle got %b exp 000", bus.issue_alu_number); end
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive(4'd5, 6'd50, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 32'd0);
      step();
      idle();
      n_vec++; if (bus.issue_alu_number !== 3'b001) begin n_err++; $display("FAIL full_drain_alu[%0d] got %b exp 001", i, bus.issue_alu_number); end
      n_vec++; if (bus.issue_dr !== 6'(i + 1)) begin n_err++; $display("FAIL full_drain_dr[%0d] got %0d exp %0d", i, bus.issue_dr, i + 1); end
      n_vec++; if (bus.issue_sr1 !== 32'hAB) begin n_err++; $display("FAIL full_drain_sr1[%0d] got %h exp ab", i, bus.issue_sr1); end
      n_vec++; if (bus.issue_imm !== 32'(i)) begin n_err++; $display("FAIL full_drain_imm[%0d] got %0d exp %0d", i, bus.issue_imm, i); end
      if (i == 0) begin
        n_vec++; if (bus.count !== 4'd7) begin n_err++; $display("FAIL full_no_slot_free got %0d exp 7", bus.count); end
      end
    end
    step();
    n_vec++; if (bus.issue_alu_number !== 3'b000) begin n_err++; $display("FAIL full_empty_alu got %b exp 000", bus.issue_alu_number); end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL full_empty_count got %0d exp 0", bus.count); end
  endtask

  task automatic test_alu_busy();
    bus.alu_busy = 3'b011;
    drive(4'd3, 6'd30, 6'd60, 1'b0, 32'd0, 6'd61, 1'b0, 32'd0, 32'h1000);  // LUI, no sources needed
    step();
    idle();
    step();
    n_vec++; if (bus.issue_alu_number !== 3'b100) begin n_err++; $display("FAIL busy_alu2 got %b exp 100", bus.issue_alu_number); end
    n_vec++; if (bus.issue_optype !== 4'd3) begin n_err++; $display("FAIL busy_lui_optype got %0d exp 3", bus.issue_optype); end
    n_vec++; if (bus.issue_imm !== 32'h1000) begin n_err++; $display("FAIL busy_lui_imm got %h exp 1000", bus.issue_imm); end
    n_vec++; if (bus.issue_dr !== 6'd30) begin n_err++; $display("FAIL busy_lui_dr got %0d exp 30", bus.issue_dr); end
    bus.alu_busy = 3'b111;
    drive(4'd2, 6'd31, 6'd0, 1'b1, 32'd2, 6'd0, 1'b0, 32'd0, 32'd1);
    step();
    idle();
    step();
    n_vec++; if (bus.issue_alu_number !== 3'b000) begin n_err++; $display("FAIL busy_all_alu got %b exp 000", bus.issue_alu_number); end
    n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL busy_retained got %0d exp 1", bus.count); end
    step();
    n_vec++; if (bus.issue_alu_number !== 3'b000) begin n_err++; $display("FAIL busy_all_alu2 got %b exp 000", bus.issue_alu_number); end
    n_vec++; if (bus.issue_dr !== 6'd30) begin n_err++; $display("FAIL busy_hold_dr got %0d exp 30", bus.issue_dr); end
    bus.alu_busy = 3'b010;
    step();
    n_vec++; if (bus.issue_alu_number !== 3'b001) begin n_err++; $display("FAIL busy_clear_alu got %b exp 001", bus.issue_alu_number); end
    n_vec++; if (bus.issue_dr !== 6'd31) begin n_err++; $display("FAIL busy_clear_dr got %0d exp 31", bus.issue_dr); end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL busy_clear_count got %0d exp 0", bus.count); end
    bus.alu_busy = 3'b000;
  endtask

  task automatic test_dispatch_issue();
    bus.alu_busy = 3'b111;
    drive(4'd2,  6'd40, 6'd0,  1'b1, 32'd1, 6'd0,  1'b0, 32'd0, 32'd4);   // ADDI ready
    step();
    drive(4'd9,  6'd41, 6'd0,  1'b1, 32'd2, 6'd45, 1'b0, 32'd0, 32'd8);   // SB waits src2
    step();
    drive(4'd4,  6'd42, 6'd45, 1'b0, 32'd0, 6'd0,  1'b0, 32'd0, 32'd5);   // ORI waits src1
    step();
    drive(4'd10, 6'd43, 6'd0,  1'b1, 32'd3, 6'd45, 1'b0, 32'd0, 32'd12);  // SW waits src2
    step();
    idle();
    n_vec++; if (bus.count !== 4'd4) begin n_err++; $display("FAIL di_fill_count got %0d exp 4", bus.count); end
    bus.alu_busy = 3'b000;
    drive(4'd1, 6'd44, 6'd45, 1'b0, 32'd0, 6'd0, 1'b1, 32'd7, 32'd0);     // ADD waits src1
    step();
    idle();
    n_vec++; if (bus.count !== 4'd4) begin n_err++; $display("FAIL di_simul_count got %0d exp 4", bus.count); end
    n_vec++; if (bus.issue_alu_number !== 3'b001) begin n_err++; $display("FAIL di_simul_alu got %b exp 001", bus.issue_alu_number); end
    n_vec++; if (bus.issue_dr !== 6'd40) begin n_err++; $display("FAIL di_simul_dr got %0d exp 40", bus.issue_dr); end
    drive(4'd0, 6'd45, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 32'd0);
    step();
    n_vec++; if (bus.count !== 4'd4) begin n_err++; $display("FAIL di_illegal0_count got %0d exp 4", bus.count); end
    n_vec++; if (bus.issue_alu_number !== 3'b000) begin n_err++; $display("FAIL di_blocked_alu got %b exp 000", bus.issue_alu_number); end
    drive(4'd11, 6'd46, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 32'd0);
    step();
    idle();
    n_vec++; if (bus.count !== 4'd4) begin n_err++; $display("FAIL di_illegal11_count got %0d exp 4", bus.count); end
    n_vec++; if (bus.issue_alu_number !== 3'b000) begin n_err++; $display("FAIL di_illegal11_alu got %b exp 000", bus.issue_alu_number); end
    cdb(6'd45, 32'h55);
    step();
    idle();
    n_vec++; if (bus.issue_alu_number !== 3'b000) begin n_err++; $display("FAIL di_wake_cycle got %b exp 000", bus.issue_alu_number); end
    step();
    n_vec++; if (bus.issue_dr !== 6'd41) begin n_err++; $display("FAIL di_order0_dr got %0d exp 41", bus.issue_dr); end
    n_vec++; if (bus.issue_optype !== 4'd9) begin n_err++; $display("FAIL di_order0_optype got %0d exp 9", bus.issue_optype); end
    n_vec++; if (bus.issue_sr1 !== 32'd2) begin n_err++; $display("FAIL di_order0_sr1 got %0d exp 2", bus.issue_sr1); end
    n_vec++; if (bus.issue_sr2 !== 32'h55) begin n_err++; $display("FAIL di_order0_sr2 got %h exp 55", bus.issue_sr2); end
    step();
    n_vec++; if (bus.issue_dr !== 6'd42) begin n_err++; $display("FAIL di_order1_dr got %0d exp 42", bus.issue_dr); end
    n_vec++; if (bus.issue_sr1 !== 32'h55) begin n_err++; $display("FAIL di_order1_sr1 got %h exp 55", bus.issue_sr1); end
    n_vec++; if (bus.issue_imm !== 32'd5) begin n_err++; $display("FAIL di_order1_imm got %0d exp 5", bus.issue_imm); end
    step();
    n_vec++; if (bus.issue_dr !== 6'd43) begin n_err++; $display("FAIL di_order2_dr got %0d exp 43", bus.issue_dr); end
    n_vec++; if (bus.issue_sr2 !== 32'h55) begin n_err++; $display("FAIL di_order2_sr2 got %h exp 55", bus.issue_sr2); end
    step();
    n_vec++; if (bus.issue_alu_number !== 3'b001) begin n_err++; $display("FAIL di_order3_alu got %b exp 001", bus.issue_alu_number); end
    n_vec++; if (bus.issue_dr !== 6'd44) begin n_err++; $display("FAIL di_order3_dr got %0d exp 44", bus.issue_dr); end
    n_vec++; if (bus.issue_sr1 !== 32'h55) begin n_err++; $display("FAIL di_order3_sr1 got %h exp 55", bus.issue_sr1); end
    n_vec++; if (bus.issue_sr2 !== 32'd7) begin n_err++; $display("FAIL di_order3_sr2 got %0d exp 7", bus.issue_sr2); end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL di_final_count got %0d exp 0", bus.count); end
  endtask

  initial begin
    rst = 1'b1;
    bus.disp_valid     = 1'b0;
    bus.disp_optype    = '0;
    bus.disp_dr        = '0;
    bus.disp_src1_tag  = '0;
    bus.disp_src2_tag  = '0;
    bus.disp_src1_rdy  = 1'b0;
    bus.disp_src2_rdy  = 1'b0;
    bus.disp_src1_data = '0;
    bus.disp_src2_data = '0;
    bus.disp_imm       = '0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_tag        = '0;
    bus.cdb_data       = '0;
    bus.alu_busy       = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    test_back_to_back();
    test_reset();
    test_cdb_wakeup();
    test_full();
    test_alu_busy();
    test_dispatch_issue();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

In-order-aged issue queue (reservation station) sitting directly upstream of the ALU bank. It holds dispatched micro-ops until their source operands are available, captures operands from the common data bus (CDB), and issues at most one ready op per cycle. It presents each issued op to the ALUs as a one-hot `alu_number`, plus optype, operands, immediate and destination tag.

## Interface
Parameters:
- `DEPTH`, 8: number of queue entries (power of two not required, ≥2)
- `NUM_ALU`, 3: number of ALUs; width of `issue_alu_number` and `alu_busy`
- `TAG_W`, 6: physical-register tag width
- `DATA_W`, 32: operand width

Ports:
- `clk` in 1: the single clock; all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `disp_valid` in 1: dispatch request this cycle
- `disp_ready` out 1: queue can accept a dispatch this cycle
- `disp_optype` in 4: 1..10 (ADD, ADDI, LUI, ORI, XOR, SRAI, LB, LW, SB, SW)
- `disp_dr` in TAG_W: destination tag
- `disp_src1_tag`, `disp_src2_tag` in TAG_W: source tags
- `disp_src1_rdy`, `disp_src2_rdy` in 1: source value already valid
- `disp_src1_data`, `disp_src2_data` in DATA_W: source value if ready
- `disp_imm` in DATA_W: immediate
- `cdb_valid` in 1, `cdb_tag` in TAG_W, `cdb_data` in DATA_W: result broadcast
- `alu_busy` in NUM_ALU: bit i high means ALU i cannot accept this cycle
- `issue_alu_number` out NUM_ALU: one-hot target ALU; all-zero means no issue
- `issue_optype` out 4, `issue_sr1` / `issue_sr2` / `issue_imm` out DATA_W, `issue_dr` out TAG_W
- `count` out $clog2(DEPTH+1): occupied entries

## Operation
- Entry fields: valid, optype, dr, per source {rdy, tag, data}, imm.
- **Ordering:** entries are kept compacted. Index 0 is the oldest entry. On issue, entries above the issued index shift down by one.
- **Need rules:**
  - src1 is needed for all optypes except 3 (LUI).
  - src2 is needed only for optypes 1, 5, 9, 10.
  - A source that is not needed counts as ready.
- **Eligibility:** an entry is eligible when it is valid and all needed sources show rdy at the start of the cycle.
- **Select:** the lowest-index eligible entry is selected. The target is the lowest-index ALU with `alu_busy[i]`=0.
  - If no entry is eligible or all ALUs are busy, `issue_alu_number` is 0 and the other issue outputs hold their previous values.
- **Wakeup:** when `cdb_valid` is high, every valid entry source with rdy=0 and a matching tag sets rdy=1 and captures `cdb_data`.
- **Dispatch:**
  - Accepted when `disp_valid && disp_ready`. The new entry is written at index `count`, or at `count`-1 if an issue occurs in the same cycle.
  - A dispatched source with rdy=0 whose tag matches a same-cycle CDB broadcast is written as ready with `cdb_data` (bypass).
- **Illegal optypes:** optype 0 or greater than 10 is silently dropped (not written; count unchanged).
- **Full:** `disp_ready` = (count < DEPTH) && !rst. Issue in the same cycle does not free a slot for that cycle's dispatch.
- **Count:** count increments on accepted dispatch and decrements on issue. A simultaneous dispatch and issue leaves it unchanged.

## Timing
- **Reset (`rst` high at an edge):**
  - All entries are invalidated and count = 0.
  - `issue_alu_number`, `issue_optype`, `issue_sr1`, `issue_sr2`, `issue_imm`, `issue_dr` = 0.
  - `disp_ready` reads 0 while `rst` is high.
  - Reset mid-operation discards all queued ops. A dispatch presented in the reset cycle is not accepted.
- **Issue outputs:** all are registered. Selection in cycle k appears on the outputs after edge k+1 and lasts exactly one cycle; the ALU consumes it combinationally.
- **Minimum latency:**
  - Dispatch with all sources ready, accepted at edge k, issues at edge k+1.
  - A source woken by CDB at edge k makes the entry eligible in the cycle after edge k, so it issues at edge k+1 at the earliest.
  - There is no same-cycle wakeup-to-select.
- **Busy sampling:** `alu_busy` is sampled in the selection cycle, and the issue is guaranteed to that ALU.

## Test plan
- **Reset:** assert `rst` with 3 valid entries. Next cycle: count=0, `issue_alu_number`=3'b000, `disp_ready`=1 after `rst` falls.
- **Back-to-back ready ADDIs:** dispatch ADDI (sr1=5, imm=7, dr=12) at cycle 0 with all ALUs free. At cycle 1 expect `issue_alu_number`=3'b001, optype=2, `issue_sr1`=5, `issue_imm`=7, `issue_dr`=12.
- **CDB wakeup, ordering and bypass:**
  - Dispatch ADD (src1 tag 20 not ready, src2=3), then XOR with both sources ready.
  - XOR issues first.
  - Broadcast tag 20 data 0x10 → ADD issues next cycle+1 with sr1=0x10.
  - Repeat with the broadcast in the same cycle as dispatch: the bypass captures 0x10.
- **Full:** fill 8 entries that are all blocked on tag 33. `disp_ready`=0 and a further dispatch is ignored (count stays 8). Broadcast tag 33 → entries issue oldest-first, one per cycle.
- **ALU busy:** `alu_busy`=3'b011 with one ready op → `issue_alu_number`=3'b100. `alu_busy`=3'b111 → no issue, the entry is retained, and it issues once `alu_busy` clears.
- **Simultaneous dispatch+issue and illegal optype:**
  - At count=4, issuing index 0 while dispatching keeps count=4, with the new entry at index 3 and older entries shifted.
  - A dispatch with optype 0 leaves count unchanged.
